// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared core-wide definitions. This slice holds the pieces used by the
//   unified-memory arbiter:
//     XLEN         - architectural register / address width
//     arb_state_e  - arbiter FSM state encoding
//     arb_owner_e  - which requester owns the in-flight memory transaction
//     mem_req_t    - a latched memory request (we, be, addr, wdata)
//     fetchReq()   - builds the request an instruction fetch turns into
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // A fetch is always a full-word read: all byte lanes on, no write data.
  function automatic mem_req_t fetchReq(input logic [XLEN-1:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = 4'hF;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating count of data grants made while a fetch was left waiting.
//   Once the count reaches LIMIT, atLimit tells the arbiter to hand the next
//   contested slot to fetch.
// Ports:
//   clk      in   clock
//   rstN     in   asynchronous active-low reset
//   inc      in   a data grant was made with fetch pending
//   clr      in   fetch was granted, or fetch is no longer waiting
//   atLimit  out  count has reached LIMIT
// Parameters:
//   LIMIT    saturation value (1..15)
// ---------------------------------------------------------------------------
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic inc,
  input  logic clr,
  output logic atLimit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LimitVal = W'(LIMIT);

  logic [W-1:0] countReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      countReg <= '0;
    end else if (clr) begin
      countReg <= '0;
    end else if (inc && (countReg != LimitVal)) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign atLimit = (countReg == LimitVal);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported unified memory between the instruction fetch
//   port (if_*) and the load/store port (dm_*). One memory transaction is in
//   flight at a time. Data requests win a contested grant; with the
//   starvation guard built in, fetch is forced after STARVE_LIMIT data grants
//   that left it waiting.
//
//   Build option: define MEM_ARB_STARVE_GUARD_EN to include the starvation
//   guard. Without it arbitration is strict data priority.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   if_req_i/if_addr_i        fetch request and address
//   if_kill_i                 flush: drop the outstanding fetch response
//   if_gnt_o                  fetch accepted (combinational, IDLE only)
//   if_rvalid_o/if_rdata_o    fetch response (rdata is 0 when not valid)
//   dm_req_i/we/be/addr/wdata data request
//   dm_gnt_o                  data accepted (combinational, IDLE only)
//   dm_rvalid_o/dm_rdata_o    data response / write acknowledge
//   mem_req_o/we/be/addr/wdata memory request, driven only in ARB_REQ
//   mem_gnt_i                 memory accepted the request
//   mem_rvalid_i/mem_rdata_i  memory response
//
// Parameters:
//   XLEN          address/data width; must equal riscv_pkg::XLEN because
//                 the latched request uses the package struct
//   STARVE_LIMIT  data grants tolerated before fetch is forced (1..15)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  input  logic            if_kill_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [3:0]      dm_be_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  import riscv_pkg::*;

  arb_state_e stateReg, stateNext;
  arb_owner_e ownerReg, ownerNext;
  mem_req_t   reqReg, reqNext;
  logic       killReg, killNext;

  logic isIdle, isReq, isResp;
  logic fetchForce;
  logic ifWins, dmWins;
  logic respFire;

  assign isIdle = (stateReg == ARB_IDLE);
  assign isReq  = (stateReg == ARB_REQ);
  assign isResp = (stateReg == ARB_RESP);

  // ------------------------------------------------------------------------
  // Starvation guard
  // ------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic starveInc;
  logic starveClr;

  assign starveInc = dm_gnt_o && if_req_i;
  assign starveClr = if_gnt_o || (isIdle && !if_req_i);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) uStarveCtr (
    .clk    (clk_i),
    .rstN   (rstn_i),
    .inc    (starveInc),
    .clr    (starveClr),
    .atLimit(fetchForce)
  );
`else
  // Strict data priority; the limit only matters when the guard is built.
  assign fetchForce = 1'b0 & STARVE_LIMIT[0];
`endif

  // ------------------------------------------------------------------------
  // Arbitration. Grants are gated with rstn_i so that asserting reset
  // silences them immediately even while requests are still held high.
  // ------------------------------------------------------------------------
  assign ifWins = rstn_i && isIdle && if_req_i && (!dm_req_i || fetchForce);
  assign dmWins = rstn_i && isIdle && dm_req_i && !(if_req_i && fetchForce);

  assign if_gnt_o = ifWins;
  assign dm_gnt_o = dmWins;

  // A response is accepted in RESP, or in REQ when the memory grants and
  // answers in the same cycle. rvalid in any other situation is ignored.
  assign respFire = mem_rvalid_i && (isResp || (isReq && mem_gnt_i));

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    ownerNext = ownerReg;
    reqNext   = reqReg;
    killNext  = killReg;

    case (stateReg)
      ARB_IDLE: begin
        killNext = 1'b0;
        if (ifWins) begin
          stateNext = ARB_REQ;
          ownerNext = OWN_IF;
          reqNext   = fetchReq(if_addr_i);
        end else if (dmWins) begin
          stateNext = ARB_REQ;
          ownerNext = OWN_DM;
          reqNext   = '{we: dm_we_i, be: dm_be_i, addr: dm_addr_i, wdata: dm_wdata_i};
        end
      end
      ARB_REQ: begin
        if (mem_gnt_i) begin
          stateNext = mem_rvalid_i ? ARB_IDLE : ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (mem_rvalid_i) begin
          stateNext = ARB_IDLE;
        end
      end
      default: begin
        stateNext = ARB_IDLE;
      end
    endcase

    // A flush seen at any point while fetch owns the memory poisons the
    // response; the memory side still runs to completion.
    if (!isIdle && (ownerReg == OWN_IF) && if_kill_i) begin
      killNext = 1'b1;
    end

    // Transaction finished: forget the owner and the kill marker.
    if (!isIdle && (stateNext == ARB_IDLE)) begin
      killNext  = 1'b0;
      ownerNext = OWN_NONE;
      reqNext   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stateReg <= ARB_IDLE;
      ownerReg <= OWN_NONE;
      reqReg   <= '0;
      killReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      ownerReg <= ownerNext;
      reqReg   <= reqNext;
      killReg  <= killNext;
    end
  end

  // ------------------------------------------------------------------------
  // Memory side: fields come straight from registers, so they are stable
  // for the whole of ARB_REQ and zero elsewhere.
  // ------------------------------------------------------------------------
  assign mem_req_o   = isReq;
  assign mem_we_o    = isReq ? reqReg.we    : 1'b0;
  assign mem_be_o    = isReq ? reqReg.be    : 4'h0;
  assign mem_addr_o  = isReq ? reqReg.addr  : '0;
  assign mem_wdata_o = isReq ? reqReg.wdata : '0;

  // ------------------------------------------------------------------------
  // Response routing. A kill arriving in the response cycle itself also
  // suppresses the fetch response.
  // ------------------------------------------------------------------------
  assign if_rvalid_o = respFire && (ownerReg == OWN_IF) && !killReg && !if_kill_i;
  assign dm_rvalid_o = respFire && (ownerReg == OWN_DM);

  assign if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o = dm_rvalid_o ? mem_rdata_i : '0;

endmodule
